// File: rtl/gamepad_pkg.sv
// Shared definitions for the DB9 gamepad scanner: button bit positions, pin
// positions inside a pad's 6-bit pin group, FSM encoding and scan phase numbers.
package gamepad_pkg;

  localparam int NUM_BTNS = 12;
  localparam int PIN_W    = 6;
  localparam int PHASE_W  = 3;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  // Bit positions of the DB9 pins within {Pino9,Pino6,Pino4,Pino3,Pino2,Pino1}
  localparam int PIN1 = 0;
  localparam int PIN2 = 1;
  localparam int PIN3 = 2;
  localparam int PIN4 = 3;
  localparam int PIN6 = 4;
  localparam int PIN9 = 5;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } scan_state_e;

  localparam phase_t PH_DPAD   = 3'd0;
  localparam phase_t PH_ASTART = 3'd1;
  localparam phase_t PH_ID     = 3'd5;
  localparam phase_t PH_XYZ    = 3'd6;

endpackage

// File: rtl/gamepad_channel.sv
// One pad: pin synchroniser, phase-decoded sampling, debounce and the
// published Saidas/Pressed/Present/SixButton registers.
module gamepad_channel
  import gamepad_pkg::*;
#(
  parameter bit SIX_BTN_EN     = 1'b1,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIN_W-1:0]    pins,
  input  phase_t              phase,
  input  logic                sample,
  input  logic                update,
  output logic [NUM_BTNS-1:0] saidas,
  output logic [NUM_BTNS-1:0] pressed,
  output logic                present,
  output logic                six_button
);

  localparam logic [2:0] DB_MAX = 3'(DEBOUNCE_SCANS);

  logic [PIN_W-1:0]    pin_meta, pin_sync;
  logic [NUM_BTNS-1:0] raw_q, prev_raw, raw_final, saidas_next;
  logic                present_q, six_q;
  logic [2:0]          db_cnt, cnt_next;

  // NOTE: non-blocking assignments make every flop see pre-edge values, so the two sync stages never collapse into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_meta <= '0;
      pin_sync <= '0;
    end else begin
      pin_meta <= pins;
      pin_sync <= pin_meta;
    end
  end

  // NOTE: sample registers are reset as well, so a scan cut short by reset leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q     <= '0;
      present_q <= 1'b0;
      six_q     <= 1'b0;
    end else if (sample) begin
      case (phase)
        PH_DPAD:   raw_q[5:0] <= ~{pin_sync[PIN9], pin_sync[PIN6], pin_sync[PIN4],
                                   pin_sync[PIN3], pin_sync[PIN2], pin_sync[PIN1]};
        PH_ASTART: begin
          raw_q[7:6] <= ~{pin_sync[PIN9], pin_sync[PIN6]};
          present_q  <= ~pin_sync[PIN3] & ~pin_sync[PIN4];
        end
        PH_ID:     six_q <= (pin_sync[PIN4:PIN1] == 4'b0000);
        PH_XYZ:    raw_q[11:8] <= ~pin_sync[PIN4:PIN1];
        default:   ;
      endcase
    end
  end

  // Absent pads read as all-released; XYZ/Mode only count for a pad that answered the ID phase.
  assign raw_final = present_q ? {(SIX_BTN_EN && six_q) ? raw_q[11:8] : 4'h0, raw_q[7:0]}
                               : '0;

  assign cnt_next    = (raw_final != prev_raw) ? 3'd1 :
                       (db_cnt >= DB_MAX)      ? DB_MAX : db_cnt + 3'd1;
  assign saidas_next = (cnt_next == DB_MAX) ? raw_final : saidas;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw   <= '0;
      db_cnt     <= '0;
      saidas     <= '0;
      pressed    <= '0;
      present    <= 1'b0;
      six_button <= 1'b0;
    end else if (update) begin
      prev_raw   <= raw_final;
      db_cnt     <= cnt_next;
      saidas     <= saidas_next;
      pressed    <= saidas_next & ~saidas;
      present    <= present_q;
      six_button <= SIX_BTN_EN && six_q;
    end else begin
      pressed <= '0;
    end
  end

endmodule

// File: rtl/gamepad_scanner.sv
// Multi-pad Sega DB9 reader: once per frame walks Select through the scan
// phases and lets each gamepad_channel sample, debounce and publish its pad.
module gamepad_scanner
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS       = 2,
  parameter bit SIX_BTN_EN     = 1'b1,
  parameter int SETTLE_CYCLES  = 100,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                         Clock50,
  input  logic                         Reset,
  input  logic                         v_sync,
  input  logic [PIN_W*NUM_PADS-1:0]    Pins,
  output logic                         Select,
  output logic [NUM_BTNS*NUM_PADS-1:0] Saidas,
  output logic [NUM_BTNS*NUM_PADS-1:0] Pressed,
  output logic [NUM_PADS-1:0]          Present,
  output logic [NUM_PADS-1:0]          SixButton,
  output logic                         ScanBusy,
  output logic                         ScanDone
);

  localparam int                    SETTLE_W    = $clog2(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0]   LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam phase_t                LAST_PHASE  = SIX_BTN_EN ? 3'd7 : 3'd1;

  scan_state_e         state, state_next;
  phase_t              phase, phase_next;
  logic [SETTLE_W-1:0] settle_cnt, settle_next;
  logic                vs_meta, vs_sync, vs_prev, vs_edge;
  logic                sample;

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
      vs_edge <= 1'b0;
    end else begin
      vs_meta <= v_sync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      vs_edge <= vs_sync & ~vs_prev;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    settle_next = settle_cnt;
    sample      = 1'b0;
    case (state)
      IDLE: begin
        phase_next  = '0;
        settle_next = '0;
        if (vs_edge) state_next = SCAN;
      end
      SCAN: begin
        if (settle_cnt == LAST_SETTLE) begin
          sample      = 1'b1;
          settle_next = '0;
          if (phase == LAST_PHASE) state_next = UPDATE;
          else                     phase_next = phase + 3'd1;
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Select and the status flags are registered from next-state so they are glitch-free.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      phase      <= '0;
      settle_cnt <= '0;
      Select     <= 1'b1;
      ScanBusy   <= 1'b0;
      ScanDone   <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      settle_cnt <= settle_next;
      Select     <= (state_next == SCAN) ? ~phase_next[0] : 1'b1;
      ScanBusy   <= (state_next == SCAN);
      ScanDone   <= (state_next == UPDATE);
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    gamepad_channel #(
      .SIX_BTN_EN    (SIX_BTN_EN),
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_channel (
      .clk       (Clock50),
      .rst_n     (Reset),
      .pins      (Pins[PIN_W*g +: PIN_W]),
      .phase     (phase),
      .sample    (sample),
      .update    (state == UPDATE),
      .saidas    (Saidas[NUM_BTNS*g +: NUM_BTNS]),
      .pressed   (Pressed[NUM_BTNS*g +: NUM_BTNS]),
      .present   (Present[g]),
      .six_button(SixButton[g])
    );
  end

endmodule

// File: tb/tb_gamepad_scanner.sv
// Directed bench: two scanners (6-button and 2-phase builds) share v_sync and
// reset, each driven by behavioural DB9 pads that react to its own Select.
module tb_gamepad_scanner;
  import gamepad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_sync;
  logic [11:0] pins0, pins1;
  logic        sel0, sel1, busy0, busy1, done0, done1;
  logic [23:0] sai0, sai1, prs0, prs1;
  logic [1:0]  pres0, pres1, six0, six1;

  logic [11:0] btn0 = '0, btn1 = '0;
  logic        att0 = 1'b0, att1 = 1'b0, cap0 = 1'b1, cap1 = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gamepad_scanner #(.NUM_PADS(2), .SIX_BTN_EN(1'b1), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)) u_dut6 (
    .Clock50(clk), .Reset(rst_n), .v_sync(v_sync), .Pins(pins0), .Select(sel0),
    .Saidas(sai0), .Pressed(prs0), .Present(pres0), .SixButton(six0),
    .ScanBusy(busy0), .ScanDone(done0)
  );

  gamepad_scanner #(.NUM_PADS(2), .SIX_BTN_EN(1'b0), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)) u_dut3 (
    .Clock50(clk), .Reset(rst_n), .v_sync(v_sync), .Pins(pins1), .Select(sel1),
    .Saidas(sai1), .Pressed(prs1), .Present(pres1), .SixButton(six1),
    .ScanBusy(busy1), .ScanDone(done1)
  );

  // Pad model: counts Select falling edges; a long high Select restarts the count.
  int fall0 = 0, fall1 = 0, base0 = 0, base1 = 0, hi0 = 0, hi1 = 0;
  always @(negedge sel0) fall0++;
  always @(negedge sel1) fall1++;
  always @(posedge clk) begin
    if (sel0 === 1'b1) hi0++; else hi0 = 0;
    if (hi0 == 16) base0 = fall0;
  end
  always @(posedge clk) begin
    if (sel1 === 1'b1) hi1++; else hi1 = 0;
    if (hi1 == 16) base1 = fall1;
  end

  // Returns {P9,P6,P4,P3,P2,P1}, active-low, pulled high when nothing is plugged in.
  function automatic logic [5:0] pad_pins(input logic sel, input int k, input logic [11:0] b,
                                           input logic att, input logic six_cap);
    if (!att) return 6'h3F;
    if (sel) begin
      if (six_cap && k == 3)
        return ~{b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
      return ~{b[BTN_C], b[BTN_B], b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
    end
    if (six_cap && k == 3) return {~b[BTN_START], ~b[BTN_A], 4'b0000};
    if (six_cap && k >= 4) return {~b[BTN_START], ~b[BTN_A], 4'b1111};
    return {~b[BTN_START], ~b[BTN_A], 2'b00, ~b[BTN_DOWN], ~b[BTN_UP]};
  endfunction

  assign pins0 = {pad_pins(sel0, fall0 - base0, btn1, att1, cap1),
                  pad_pins(sel0, fall0 - base0, btn0, att0, cap0)};
  assign pins1 = {pad_pins(sel1, fall1 - base1, btn1, att1, cap1),
                  pad_pins(sel1, fall1 - base1, btn0, att0, cap0)};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: idle gap, v_sync edge, 3 cycles to detection, 32 SCAN cycles,
  // UPDATE cycle, then one more cycle so registered outputs are visible.
  task automatic run_scan(input bit chk);
    int exp_sel;
    repeat (20) step();
    @(negedge clk);
    v_sync = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 32; i++) begin
      step();
      if (chk) begin
        exp_sel = ((i / 4) % 2 == 0) ? 1 : 0;
        check("select_phase", 32'(sel0), exp_sel);
        check("busy_in_scan", 32'(busy0), 1);
        if (i == 7) check("done_2phase_early", 32'(done1), 0);
        if (i == 8) check("done_2phase_lat9", 32'(done1), 1);
      end
    end
    step();
    check("done_lat33", 32'(done0), 1);
    check("select_after_scan", 32'(sel0), 1);
    check("busy_after_scan", 32'(busy0), 0);
    v_sync = 1'b0;
    step();
  endtask

  initial begin
    int extra_busy;
    rst_n  = 1'b0;
    v_sync = 1'b0;

    // T1: reset held while v_sync toggles
    for (int i = 0; i < 8; i++) begin
      v_sync = (i % 2 == 1);
      step();
      check("rst_select", 32'(sel0), 1);
      check("rst_saidas", 32'(sai0), 0);
      check("rst_busy", 32'(busy0), 0);
    end
    v_sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2: pad0 six-button holding A+Up, pad1 unplugged
    att0 = 1'b1;
    btn0 = 12'h041;  // A (bit 6) + Up (bit 0)
    run_scan(1'b1);
    check("t2_present", 32'(pres0), 32'h1);
    check("t2_six", 32'(six0), 32'h1);
    check("t2_saidas_first", 32'(sai0[11:0]), 0);
    check("t2_pressed_first", 32'(prs0), 0);
    check("t2_present_2ph", 32'(pres1), 32'h1);
    check("t2_six_2ph", 32'(six1), 0);

    // T3: second identical scan publishes, Pressed is a single-cycle pulse
    run_scan(1'b1);
    check("t3_saidas", 32'(sai0[11:0]), 32'h041);
    check("t3_pressed", 32'(prs0[11:0]), 32'h041);
    check("t3_saidas_2ph", 32'(sai1[11:0]), 32'h041);
    step();
    check("t3_pressed_gone", 32'(prs0), 0);
    check("t3_saidas_held", 32'(sai0[11:0]), 32'h041);
    run_scan(1'b0);
    check("t3_third_pressed", 32'(prs0), 0);
    check("t3_third_saidas", 32'(sai0), 32'h041);

    // T4: pad1 shows C for a single scan only
    att1 = 1'b1;
    btn1 = 12'h020;
    run_scan(1'b0);
    check("t4_present_both", 32'(pres0), 32'h3);
    check("t4_glitch_saidas", 32'(sai0[23:12]), 0);
    check("t4_glitch_pressed", 32'(prs0[23:12]), 0);
    btn1 = 12'h000;
    run_scan(1'b0);
    check("t4_after_saidas", 32'(sai0[23:12]), 0);
    check("t4_after_pressed", 32'(prs0[23:12]), 0);

    // T5: Mode+X on pad0; 2-phase build cannot see them
    btn0 = 12'hC00;  // Mode (bit 11) + X (bit 10)
    run_scan(1'b0);
    check("t5_first_keeps_old", 32'(sai0[11:0]), 32'h041);
    run_scan(1'b0);
    check("t5_saidas", 32'(sai0[11:0]), 32'hC00);
    check("t5_pressed", 32'(prs0[11:0]), 32'hC00);
    check("t5_saidas_2ph", 32'(sai1[11:0]), 0);
    check("t5_six_2ph", 32'(six1), 0);

    // 3-button pad on pad1: Mode is invisible, Start is kept
    cap1 = 1'b0;
    btn1 = 12'h880;
    run_scan(1'b0);
    run_scan(1'b0);
    check("3btn_saidas", 32'(sai0[23:12]), 32'h080);
    check("3btn_six", 32'(six0), 32'h1);

    // T6a: a second v_sync edge during SCAN starts nothing
    repeat (20) step();
    @(negedge clk);
    v_sync = 1'b1;
    repeat (13) step();
    v_sync = 1'b0;
    repeat (2) step();
    v_sync = 1'b1;
    repeat (21) step();
    check("t6_done_once", 32'(done0), 1);
    v_sync = 1'b0;
    extra_busy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy0 !== 1'b0) extra_busy++;
    end
    check("t6_no_rescan", extra_busy, 0);
    check("t6_saidas_kept", 32'(sai0), 32'h080C00);

    // T6b: reset pulse in phase 3
    repeat (20) step();
    @(negedge clk);
    v_sync = 1'b1;
    repeat (17) step();
    check("t6_phase3_select", 32'(sel0), 0);
    check("t6_phase3_busy", 32'(busy0), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_select", 32'(sel0), 1);
    check("t6_rst_busy", 32'(busy0), 0);
    check("t6_rst_saidas", 32'(sai0), 0);
    check("t6_rst_done", 32'(done0), 0);
    repeat (2) step();
    v_sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b1);
    check("t6_clean_saidas", 32'(sai0), 0);
    check("t6_clean_present", 32'(pres0), 32'h3);
    run_scan(1'b0);
    check("t6_clean_republish", 32'(sai0), 32'h080C00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
